// File: rtl/cpu_decode.sv
// RV32I decode stage: drives register-file read addresses and registers decoded fields, 1-cycle latency.
// Single-entry slot: instr_ready = !dec_valid || dec_ready; a stall holds every field except operands, which follow writes.
module cpu_decode (
  input  logic        CLK,
  input  logic        RST,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  input  logic [31:0] rs1_in,
  input  logic [31:0] rs2_in,
  input  logic [31:0] wb_rd,
  input  logic [4:0]  wb_rd_addr,
  input  logic        wb_rd_en,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_pc,
  output logic [3:0]  dec_op,
  output logic [2:0]  dec_funct3,
  output logic        dec_funct7b5,
  output logic [4:0]  dec_rd_addr,
  output logic        dec_rd_we,
  output logic [31:0] dec_imm,
  output logic [31:0] dec_rs1_data,
  output logic [31:0] dec_rs2_data,
  output logic        dec_illegal
);

  localparam logic [3:0] OP_LUI    = 4'd0;
  localparam logic [3:0] OP_AUIPC  = 4'd1;
  localparam logic [3:0] OP_JAL    = 4'd2;
  localparam logic [3:0] OP_JALR   = 4'd3;
  localparam logic [3:0] OP_BRANCH = 4'd4;
  localparam logic [3:0] OP_LOAD   = 4'd5;
  localparam logic [3:0] OP_STORE  = 4'd6;
  localparam logic [3:0] OP_OPIMM  = 4'd7;
  localparam logic [3:0] OP_OP     = 4'd8;
  localparam logic [3:0] OP_MISC   = 4'd9;
  localparam logic [3:0] OP_SYSTEM = 4'd10;
  localparam logic [3:0] OP_ILL    = 4'd15;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [4:0]  rd_addr;
    logic [31:0] imm;
    logic        illegal;
  } dec_t;

  logic        dec_valid_q, dec_valid_d;
  dec_t        dec_q, dec_d;
  dec_t        dec_new;
  logic [4:0]  rs1_addr_q, rs1_addr_d;
  logic [4:0]  rs2_addr_q, rs2_addr_d;
  logic        byp1_q, byp1_d;
  logic        byp2_q, byp2_d;
  logic [31:0] bypdata1_q, bypdata1_d;
  logic [31:0] bypdata2_q, bypdata2_d;

  logic        accept;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign instr_ready = !dec_valid_q || dec_ready;
  assign accept      = instr_valid && instr_ready;

  // Addresses follow the incoming instruction only on accept; otherwise the
  // held addresses are re-read so writes landing during a stall are picked up.
  assign rs1_addr = accept ? instr[19:15] : rs1_addr_q;
  assign rs2_addr = accept ? instr[24:20] : rs2_addr_q;

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    dec_new          = '0;
    dec_new.pc       = pc;
    dec_new.funct3   = instr[14:12];
    dec_new.funct7b5 = instr[30];
    dec_new.rd_addr  = instr[11:7];
    dec_new.op       = OP_ILL;
    dec_new.imm      = '0;
    dec_new.illegal  = 1'b1;
    if (instr[1:0] == 2'b11) begin
      dec_new.illegal = 1'b0;
      case (instr[6:2])
        5'b01101: begin dec_new.op = OP_LUI;    dec_new.imm = imm_u; end
        5'b00101: begin dec_new.op = OP_AUIPC;  dec_new.imm = imm_u; end
        5'b11011: begin dec_new.op = OP_JAL;    dec_new.imm = imm_j; end
        5'b11001: begin dec_new.op = OP_JALR;   dec_new.imm = imm_i; end
        5'b11000: begin dec_new.op = OP_BRANCH; dec_new.imm = imm_b; end
        5'b00000: begin dec_new.op = OP_LOAD;   dec_new.imm = imm_i; end
        5'b01000: begin dec_new.op = OP_STORE;  dec_new.imm = imm_s; end
        5'b00100: begin dec_new.op = OP_OPIMM;  dec_new.imm = imm_i; end
        5'b01100: begin dec_new.op = OP_OP;     dec_new.imm = '0;    end
        5'b00011: begin dec_new.op = OP_MISC;   dec_new.imm = imm_i; end
        5'b11100: begin dec_new.op = OP_SYSTEM; dec_new.imm = imm_i; end
        default:  begin dec_new.op = OP_ILL;    dec_new.illegal = 1'b1; end
      endcase
    end
    if (dec_new.illegal || dec_new.op == OP_BRANCH ||
        dec_new.op == OP_STORE || dec_new.op == OP_MISC) begin
      dec_new.rd_addr = '0;
    end
  end

  always_comb begin
    dec_valid_d = dec_valid_q;
    dec_d       = dec_q;
    rs1_addr_d  = rs1_addr_q;
    rs2_addr_d  = rs2_addr_q;
    if (accept) begin
      dec_valid_d = 1'b1;
      dec_d       = dec_new;
      rs1_addr_d  = instr[19:15];
      rs2_addr_d  = instr[24:20];
    end else if (dec_ready) begin
      dec_valid_d = 1'b0;
    end
  end

  // Register file reads before it writes on the same edge, so a matching
  // write is captured here and substituted for the stale read next cycle.
  always_comb begin
    byp1_d     = wb_rd_en && (wb_rd_addr == rs1_addr) && (rs1_addr != 5'd0);
    byp2_d     = wb_rd_en && (wb_rd_addr == rs2_addr) && (rs2_addr != 5'd0);
    bypdata1_d = byp1_d ? wb_rd : bypdata1_q;
    bypdata2_d = byp2_d ? wb_rd : bypdata2_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      dec_valid_q <= 1'b0;
      dec_q       <= '0;
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
      byp1_q      <= 1'b0;
      byp2_q      <= 1'b0;
      bypdata1_q  <= '0;
      bypdata2_q  <= '0;
    end else begin
      dec_valid_q <= dec_valid_d;
      dec_q       <= dec_d;
      rs1_addr_q  <= rs1_addr_d;
      rs2_addr_q  <= rs2_addr_d;
      byp1_q      <= byp1_d;
      byp2_q      <= byp2_d;
      bypdata1_q  <= bypdata1_d;
      bypdata2_q  <= bypdata2_d;
    end
  end

  assign dec_valid    = dec_valid_q;
  assign dec_pc       = dec_q.pc;
  assign dec_op       = dec_q.op;
  assign dec_funct3   = dec_q.funct3;
  assign dec_funct7b5 = dec_q.funct7b5;
  assign dec_rd_addr  = dec_q.rd_addr;
  assign dec_rd_we    = (dec_q.rd_addr != 5'd0);
  assign dec_imm      = dec_q.imm;
  assign dec_illegal  = dec_q.illegal;

  assign dec_rs1_data = (rs1_addr_q == 5'd0) ? 32'd0 : (byp1_q ? bypdata1_q : rs1_in);
  assign dec_rs2_data = (rs2_addr_q == 5'd0) ? 32'd0 : (byp2_q ? bypdata2_q : rs2_in);

endmodule

// File: tb/tb_cpu_decode.sv
// Bench for cpu_decode with a read-first, 1-cycle-latency register file model.
module tb_cpu_decode;

  logic        CLK, RST;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, pc;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_in, rs2_in;
  logic [31:0] wb_rd;
  logic [4:0]  wb_rd_addr;
  logic        wb_rd_en;
  logic        dec_valid, dec_ready;
  logic [31:0] dec_pc;
  logic [3:0]  dec_op;
  logic [2:0]  dec_funct3;
  logic        dec_funct7b5;
  logic [4:0]  dec_rd_addr;
  logic        dec_rd_we;
  logic [31:0] dec_imm, dec_rs1_data, dec_rs2_data;
  logic        dec_illegal;

  cpu_decode dut (
    .CLK(CLK), .RST(RST),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .pc(pc),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_in(rs1_in), .rs2_in(rs2_in),
    .wb_rd(wb_rd), .wb_rd_addr(wb_rd_addr), .wb_rd_en(wb_rd_en),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_pc(dec_pc), .dec_op(dec_op), .dec_funct3(dec_funct3),
    .dec_funct7b5(dec_funct7b5), .dec_rd_addr(dec_rd_addr), .dec_rd_we(dec_rd_we),
    .dec_imm(dec_imm), .dec_rs1_data(dec_rs1_data), .dec_rs2_data(dec_rs2_data),
    .dec_illegal(dec_illegal)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [31:0] regs [32];
  always @(posedge CLK) begin
    if (RST) begin
      for (int k = 0; k < 32; k++) regs[k] <= '0;
    end else if (wb_rd_en && wb_rd_addr != 5'd0) begin
      regs[wb_rd_addr] <= wb_rd;
    end
    rs1_in <= regs[rs1_addr];
    rs2_in <= regs[rs2_addr];
  end

  int total  = 0;
  int passed = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    wb_rd_en = 1'b1; wb_rd_addr = a; wb_rd = d;
    tick();
    wb_rd_en = 1'b0;
  endtask

  typedef struct {
    logic [31:0] ins;
    logic [3:0]  op;
    logic [2:0]  f3;
    logic        f7b5;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        ill;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } vec_t;

  vec_t vecs [14];

  initial begin
    //          instr          op  f3 f7 rd imm           ill rs1        rs2
    vecs[0]  = '{32'hFFC28193, 7,  0, 1, 3, 32'hFFFFFFFC, 0, 32'h11,    32'h0};
    vecs[1]  = '{32'h12345537, 0,  5, 0, 10, 32'h12345000, 0, 32'h0,    32'h0};
    vecs[2]  = '{32'h00001097, 1,  1, 0, 1, 32'h00001000, 0, 32'h0,     32'h0};
    vecs[3]  = '{32'h008000EF, 2,  0, 0, 1, 32'h00000008, 0, 32'h0,     32'h0};
    vecs[4]  = '{32'h00000000, 15, 0, 0, 0, 32'h0,        1, 32'h0,     32'h0};
    vecs[5]  = '{32'h00008067, 3,  0, 0, 0, 32'h0,        0, 32'h0,     32'h0};
    vecs[6]  = '{32'hFE628CE3, 4,  0, 1, 0, 32'hFFFFFFF8, 0, 32'h11,    32'h200};
    vecs[7]  = '{32'h00C32483, 5,  2, 0, 9, 32'h0000000C, 0, 32'h200,   32'h0};
    vecs[8]  = '{32'h00732423, 6,  2, 0, 0, 32'h00000008, 0, 32'h200,   32'h77};
    vecs[9]  = '{32'h40628233, 8,  0, 1, 4, 32'h0,        0, 32'h11,    32'h200};
    vecs[10] = '{32'h0FF0000F, 9,  0, 0, 0, 32'h000000FF, 0, 32'h0,     32'h0};
    vecs[11] = '{32'h00000073, 10, 0, 0, 0, 32'h0,        0, 32'h0,     32'h0};
    vecs[12] = '{32'h00000FFF, 15, 0, 0, 0, 32'h0,        1, 32'h0,     32'h0};
    vecs[13] = '{32'h00100092, 15, 0, 0, 0, 32'h0,        1, 32'h0,     32'h0};

    RST = 1'b1; instr_valid = 1'b0; instr = '0; pc = '0; dec_ready = 1'b1;
    wb_rd = '0; wb_rd_addr = '0; wb_rd_en = 1'b0;
    tick();
    tick();
    chk("rst instr_ready", instr_ready, 1);
    chk("rst dec_valid", dec_valid, 0);
    RST = 1'b0;
    tick();
    chk("post-rst instr_ready", instr_ready, 1);
    chk("post-rst dec_valid", dec_valid, 0);
    chk("post-rst dec_pc", dec_pc, 0);
    chk("post-rst dec_op", dec_op, 0);
    chk("post-rst dec_imm", dec_imm, 0);
    chk("post-rst dec_rd", {dec_rd_we, dec_funct7b5, dec_funct3, dec_rd_addr}, 0);
    chk("post-rst rs1_data", dec_rs1_data, 0);
    chk("post-rst rs2_data", dec_rs2_data, 0);

    wb_write(5'd2, 32'h22);
    wb_write(5'd5, 32'h11);
    wb_write(5'd6, 32'h200);
    wb_write(5'd7, 32'h77);

    // Back-to-back stream, one accept per cycle.
    dec_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      instr_valid = 1'b1;
      instr = vecs[i].ins;
      pc = 32'h100 + 32'(i * 4);
      tick();
      chk($sformatf("v%0d valid", i), dec_valid, 1);
      chk($sformatf("v%0d ready", i), instr_ready, 1);
      chk($sformatf("v%0d pc", i), dec_pc, 32'h100 + 32'(i * 4));
      chk($sformatf("v%0d op", i), dec_op, vecs[i].op);
      chk($sformatf("v%0d funct3", i), dec_funct3, vecs[i].f3);
      chk($sformatf("v%0d funct7b5", i), dec_funct7b5, vecs[i].f7b5);
      chk($sformatf("v%0d rd", i), dec_rd_addr, vecs[i].rd);
      chk($sformatf("v%0d rd_we", i), dec_rd_we, (vecs[i].rd != 5'd0) ? 1 : 0);
      chk($sformatf("v%0d imm", i), dec_imm, vecs[i].imm);
      chk($sformatf("v%0d illegal", i), dec_illegal, vecs[i].ill);
      chk($sformatf("v%0d rs1_data", i), dec_rs1_data, vecs[i].rs1);
      chk($sformatf("v%0d rs2_data", i), dec_rs2_data, vecs[i].rs2);
    end
    instr_valid = 1'b0;
    tick();
    chk("drain dec_valid", dec_valid, 0);

    // Same-edge write to both source registers.
    instr_valid = 1'b1; instr = 32'h002100B3; pc = 32'h200;
    wb_rd_en = 1'b1; wb_rd_addr = 5'd2; wb_rd = 32'hDEADBEEF;
    tick();
    chk("byp rs1_data", dec_rs1_data, 32'hDEADBEEF);
    chk("byp rs2_data", dec_rs2_data, 32'hDEADBEEF);
    chk("byp rd", dec_rd_addr, 1);

    // x0 write on the accept edge never reaches operands.
    instr = 32'h00000233; pc = 32'h204;
    wb_rd_addr = 5'd0; wb_rd = 32'h1234;
    tick();
    chk("x0 rs1_data", dec_rs1_data, 0);
    chk("x0 rs2_data", dec_rs2_data, 0);
    chk("x0 rd_we", dec_rd_we, 1);
    chk("x0 pc", dec_pc, 32'h204);
    wb_rd_en = 1'b0; instr_valid = 1'b0;
    tick();

    // Stall holding SW x7,8(x6) while x7 is rewritten.
    dec_ready = 1'b0; instr_valid = 1'b1; instr = 32'h00732423; pc = 32'h300;
    tick();
    chk("stall valid", dec_valid, 1);
    chk("stall instr_ready", instr_ready, 0);
    chk("stall rs2 pre", dec_rs2_data, 32'h77);
    instr = 32'h002100B3; pc = 32'h400;
    wb_rd_en = 1'b1; wb_rd_addr = 5'd7; wb_rd = 32'h55;
    tick();
    wb_rd_en = 1'b0;
    chk("stall rs2 bypass", dec_rs2_data, 32'h55);
    chk("stall rs1", dec_rs1_data, 32'h200);
    chk("stall pc held", dec_pc, 32'h300);
    chk("stall op held", dec_op, 6);
    chk("stall imm held", dec_imm, 8);
    chk("stall rd_we", dec_rd_we, 0);
    tick();
    chk("stall rs2 regfile", dec_rs2_data, 32'h55);
    chk("stall pc still", dec_pc, 32'h300);
    instr_valid = 1'b0; dec_ready = 1'b1;
    #1;
    chk("release instr_ready", instr_ready, 1);
    tick();
    chk("release dec_valid", dec_valid, 0);

    // Reset while holding an instruction, with a competing accept.
    dec_ready = 1'b0; instr_valid = 1'b1; instr = 32'h12345537; pc = 32'h500;
    tick();
    chk("pre-rst valid", dec_valid, 1);
    RST = 1'b1; instr = 32'h008000EF; pc = 32'h504;
    tick();
    chk("mid-rst valid", dec_valid, 0);
    chk("mid-rst pc", dec_pc, 0);
    chk("mid-rst imm", dec_imm, 0);
    chk("mid-rst instr_ready", instr_ready, 1);
    RST = 1'b0; instr_valid = 1'b0;
    tick();
    chk("after-rst valid", dec_valid, 0);
    chk("after-rst op", dec_op, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
